// File: rtl/msel_pkg.sv
// Shared definitions for the multiply-compare-select accumulator.
//   - 2-bit state encoding constants and the FSM state enum (IDLE, MULT, SEL, OUT).
package msel_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_MULT_ENC = 2'd1;
  localparam logic [1:0] ST_SEL_ENC  = 2'd2;
  localparam logic [1:0] ST_OUT_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    MULT = ST_MULT_ENC,
    SEL  = ST_SEL_ENC,
    OUT  = ST_OUT_ENC
  } state_e;

endpackage

// File: rtl/mul_select_acc_if.sv
// Operand/result bus of mul_select_acc.
//   master : drives in_valid, in_data, in_coef, in_alt, in_bias, out_ready
//   slave  : drives in_ready, out_valid, out_data, out_zero
// Handshake: a beat transfers on the rising clock edge where valid && ready are
// both high. A producer holds valid and its payload stable until that edge; the
// consumer may raise or drop ready freely. Valid never depends on ready.
interface mul_select_acc_if #(
  parameter int DW = 3,
  parameter int CW = 32,
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_coef;
  logic          in_alt;
  logic          in_bias;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_zero;

  modport master (
    output in_valid, in_data, in_coef, in_alt, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_coef, in_alt, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/msel_mul.sv
// Multi-cycle multiplier for mul_select_acc.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle pulse; a and b must stay stable until done
//   a (CW), b (AW) : operands
//   prod (AW)  : (a*b) truncated to AW bits, registered on the done edge
//   done       : high in the last of MUL_LAT busy cycles
module msel_mul
  import msel_pkg::*;
#(
  parameter int CW      = 32,
  parameter int AW      = 32,
  parameter int MUL_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] prod,
  output logic          done
);

  localparam int PW = CW + AW;

  logic          busy_q, busy_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] prod_q, prod_d;
  logic [PW-1:0] full_prod;

  // Full-width product; only the low AW bits are kept, so a product that is
  // non-zero only above bit AW-1 reads back as zero.
  assign full_prod = PW'(a) * PW'(b);
  assign done      = busy_q && (cnt_q == 4'd0);
  assign prod      = prod_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 4'(MUL_LAT - 1);
    end else if (done) begin
      busy_d = 1'b0;
      prod_d = full_prod[AW-1:0];
    end else if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      prod_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/mul_select_acc.sv
// Multiply-compare-select accumulator.
// Accepts an operand, multiplies it by a coefficient over MUL_LAT cycles, adds
// (prod != 0 ? 0 : alt) + bias into a running accumulator and presents it.
//   clk, rst_n : clock, synchronous active-low reset
//   acc_clr    : synchronous accumulator clear, wins over the SEL add
//   bus        : mul_select_acc_if slave (operand in, result out)
//   dbg_state  : current FSM state
// Build option: MSEL_ACC_SAT_EN makes the accumulate saturate at 2^AW-1
// instead of wrapping modulo 2^AW.
module mul_select_acc
  import msel_pkg::*;
#(
  parameter int DW      = 3,
  parameter int CW      = 32,
  parameter int AW      = 32,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_clr,
  mul_select_acc_if.slave      bus,
  output state_e               dbg_state
);

  state_e        state_q, state_d;
  logic [AW-1:0] h_q, h_d;
  logic [CW-1:0] coef_q, coef_d;
  logic          alt_q, alt_d;
  logic          bias_q, bias_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          zero_q, zero_d;

  logic [DW-1:0] in_data_w;
  logic          mul_start;
  logic          mul_done;
  logic [AW-1:0] prod_w;
  logic          f_w;
  logic [AW:0]   sum_w;
  logic [AW-1:0] add_w;

  assign in_data_w     = bus.in_data;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = acc_q;
  assign bus.out_zero  = zero_q;
  assign dbg_state     = state_q;

  msel_mul #(
    .CW     (CW),
    .AW     (AW),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a    (coef_q),
    .b    (h_q),
    .prod (prod_w),
    .done (mul_done)
  );

  // One extra carry bit lets the saturating build detect overflow.
  assign f_w   = (prod_w != '0) ? 1'b0 : alt_q;
  assign sum_w = {1'b0, acc_q} + {{AW{1'b0}}, f_w} + {{AW{1'b0}}, bias_q};
`ifdef MSEL_ACC_SAT_EN
  assign add_w = sum_w[AW] ? {AW{1'b1}} : sum_w[AW-1:0];
`else
  assign add_w = sum_w[AW-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    coef_d    = coef_q;
    alt_d     = alt_q;
    bias_d    = bias_q;
    acc_d     = acc_q;
    zero_d    = zero_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          h_d       = AW'(in_data_w);
          coef_d    = bus.in_coef;
          alt_d     = bus.in_alt;
          bias_d    = bus.in_bias;
          mul_start = 1'b1;
          state_d   = MULT;
        end
      end
      MULT: begin
        if (mul_done) state_d = SEL;
      end
      SEL: begin
        acc_d   = add_w;
        zero_d  = (prod_w == '0);
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear applies in every state and discards a same-cycle SEL add.
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      coef_q  <= '0;
      alt_q   <= 1'b0;
      bias_q  <= 1'b0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      coef_q  <= coef_d;
      alt_q   <= alt_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_mul_select_acc.sv
// Bench for mul_select_acc. Three instances share one stimulus path:
//   sel 0 : AW=32, MUL_LAT=1   sel 1 : AW=4, MUL_LAT=1   sel 2 : AW=32, MUL_LAT=4
module tb_mul_select_acc;
  import msel_pkg::*;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        drv_valid;
  logic [2:0]  drv_data;
  logic [31:0] drv_coef;
  logic        drv_alt;
  logic        drv_bias;
  logic        drv_out_ready;
  logic        drv_clr;

  int total;
  int bad;

  logic [32:0] exp_q[$];
  logic [31:0] exp_acc [3];

  mul_select_acc_if #(.DW(3), .CW(32), .AW(32)) ifa ();
  mul_select_acc_if #(.DW(3), .CW(32), .AW(4))  ifb ();
  mul_select_acc_if #(.DW(3), .CW(32), .AW(32)) ifc ();

  state_e st_a, st_b, st_c;
  logic   clr_a, clr_b, clr_c;

  assign ifa.in_valid = drv_valid && (sel == 0);
  assign ifb.in_valid = drv_valid && (sel == 1);
  assign ifc.in_valid = drv_valid && (sel == 2);
  assign ifa.in_data = drv_data;  assign ifb.in_data = drv_data;  assign ifc.in_data = drv_data;
  assign ifa.in_coef = drv_coef;  assign ifb.in_coef = drv_coef;  assign ifc.in_coef = drv_coef;
  assign ifa.in_alt  = drv_alt;   assign ifb.in_alt  = drv_alt;   assign ifc.in_alt  = drv_alt;
  assign ifa.in_bias = drv_bias;  assign ifb.in_bias = drv_bias;  assign ifc.in_bias = drv_bias;
  assign ifa.out_ready = drv_out_ready;
  assign ifb.out_ready = drv_out_ready;
  assign ifc.out_ready = drv_out_ready;
  assign clr_a = drv_clr && (sel == 0);
  assign clr_b = drv_clr && (sel == 1);
  assign clr_c = drv_clr && (sel == 2);

  mul_select_acc #(.DW(3), .CW(32), .AW(32), .MUL_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .acc_clr(clr_a), .bus(ifa.slave), .dbg_state(st_a));
  mul_select_acc #(.DW(3), .CW(32), .AW(4), .MUL_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .acc_clr(clr_b), .bus(ifb.slave), .dbg_state(st_b));
  mul_select_acc #(.DW(3), .CW(32), .AW(32), .MUL_LAT(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .acc_clr(clr_c), .bus(ifc.slave), .dbg_state(st_c));

  logic        obs_valid, obs_ready, obs_zero;
  logic [31:0] obs_data;
  state_e      obs_state;

  always_comb begin
    obs_valid = ifa.out_valid;
    obs_ready = ifa.in_ready;
    obs_zero  = ifa.out_zero;
    obs_data  = ifa.out_data;
    obs_state = st_a;
    if (sel == 1) begin
      obs_valid = ifb.out_valid;
      obs_ready = ifb.in_ready;
      obs_zero  = ifb.out_zero;
      obs_data  = 32'(ifb.out_data);
      obs_state = st_b;
    end else if (sel == 2) begin
      obs_valid = ifc.out_valid;
      obs_ready = ifc.in_ready;
      obs_zero  = ifc.out_zero;
      obs_data  = ifc.out_data;
      obs_state = st_c;
    end
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int aw_of(input int s);
    return (s == 1) ? 4 : 32;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 2) ? 4 : 1;
  endfunction

  // reference model: returns {zero, acc} for one transaction
  task automatic model_step(input int s, input logic [2:0] d, input logic [31:0] c,
                            input logic a, input logic b, input bit clr,
                            output logic [32:0] e);
    logic [63:0] mask, prod, sum;
    logic        f;
    mask = (64'd1 << aw_of(s)) - 64'd1;
    prod = (64'(d) * 64'(c)) & mask;
    f    = (prod != 64'd0) ? 1'b0 : a;
    sum  = 64'(exp_acc[s]) + 64'(f) + 64'(b);
`ifdef MSEL_ACC_SAT_EN
    if (sum > mask) sum = mask;
`else
    sum = sum & mask;
`endif
    if (clr) sum = 64'd0;
    exp_acc[s] = sum[31:0];
    e = {(prod == 64'd0), sum[31:0]};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_acc[i] = 32'd0;
    exp_q.delete();
  endtask

  // driver + scoreboard for one transaction
  task automatic run_txn(input int s, input logic [2:0] d, input logic [31:0] c,
                         input logic a, input logic b, input bit clr_sel, input int hold);
    logic [32:0] e;
    logic [31:0] held;
    int          k;
    bit          seen;
    model_step(s, d, c, a, b, clr_sel, e);
    exp_q.push_back(e);
    sel = s;
    drv_out_ready = 1'b0;
    @(negedge clk);
    drv_data = d; drv_coef = c; drv_alt = a; drv_bias = b; drv_valid = 1'b1;
    total++;
    if (obs_ready !== 1'b1) begin
      bad++; $display("FAIL in_ready_idle sel=%0d got=%b exp=1", s, obs_ready);
    end
    @(posedge clk);
    #1 drv_valid = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      drv_clr = 1'b0;
      if (obs_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (clr_sel && k == lat_of(s) + 1) drv_clr = 1'b1;
    end
    total++;
    if (!seen || k != lat_of(s) + 2) begin
      bad++; $display("FAIL latency sel=%0d got=%0d exp=%0d (seen=%0d)", s, k, lat_of(s) + 2, seen);
    end
    e = exp_q.pop_front();
    if (!seen) return;
    total++;
    if (obs_data !== e[31:0]) begin
      bad++; $display("FAIL out_data sel=%0d got=%0h exp=%0h", s, obs_data, e[31:0]);
    end
    total++;
    if (obs_zero !== e[32]) begin
      bad++; $display("FAIL out_zero sel=%0d got=%b exp=%b", s, obs_zero, e[32]);
    end
    held = obs_data;
    for (int i = 0; i < hold; i++) begin
      drv_valid = 1'b1;
      @(negedge clk);
      total++;
      if (obs_valid !== 1'b1 || obs_data !== held || obs_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold cyc=%0d valid=%b data=%0h ready=%b exp valid=1 data=%0h ready=0",
                 i, obs_valid, obs_data, obs_ready, held);
      end
    end
    drv_valid = 1'b0;
    drv_out_ready = 1'b1;
    @(posedge clk);
    #1 drv_out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      bad++; $display("FAIL release sel=%0d valid=%b ready=%b exp valid=0 ready=1", s, obs_valid, obs_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clk);
      total++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_data !== 32'd0 ||
          obs_zero !== 1'b0 || obs_state !== IDLE) begin
        bad++;
        $display("FAIL reset sel=%0d valid=%b ready=%b data=%0h zero=%b state=%0d exp 0/1/0/0/0",
                 s, obs_valid, obs_ready, obs_data, obs_zero, obs_state);
      end
    end
  endtask

  task automatic test_basic();
    run_txn(0, 3'd3, 32'd2, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_zero_product();
    run_txn(0, 3'd0, 32'd5, 1'b1, 1'b1, 1'b0, 0);
    run_txn(0, 3'd0, 32'd5, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn(0, 3'd1, 32'd7, 1'b1, 1'b1, 1'b0, 10);
    run_txn(0, 3'd0, 32'd9, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] c;
      c = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_txn((i % 2 == 0) ? 0 : 2, 3'($urandom_range(0, 7)), c,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2));
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) run_txn(1, 3'd0, 32'd0, 1'b1, 1'b1, 1'b0, 0);
    run_txn(1, 3'd1, 32'd1, 1'b0, 1'b1, 1'b0, 0);
    run_txn(1, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_truncation();
    run_txn(1, 3'd4, 32'd4, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_clr_sel();
    run_txn(0, 3'd0, 32'd3, 1'b1, 1'b1, 1'b0, 0);
    run_txn(0, 3'd0, 32'd3, 1'b1, 1'b1, 1'b1, 0);
  endtask

  task automatic test_reset_mid_mult();
    bit rose;
    sel = 2;
    @(negedge clk);
    drv_data = 3'd2; drv_coef = 32'd3; drv_alt = 1'b1; drv_bias = 1'b1; drv_valid = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs_state !== MULT) begin
      bad++; $display("FAIL mid_mult_state got=%0d exp=%0d", obs_state, MULT);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_acc[i] = 32'd0;
    @(negedge clk);
    total++;
    if (obs_state !== IDLE || obs_ready !== 1'b1 || obs_data !== 32'd0) begin
      bad++; $display("FAIL mid_mult_reset state=%0d ready=%b data=%0h exp 0/1/0", obs_state, obs_ready, obs_data);
    end
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (obs_valid !== 1'b0) rose = 1'b1;
    end
    total++;
    if (rose) begin
      bad++; $display("FAIL mid_mult_valid got=1 exp=0");
    end
  endtask

  initial begin
    total = 0; bad = 0;
    sel = 0; drv_valid = 1'b0; drv_data = '0; drv_coef = '0; drv_alt = 1'b0;
    drv_bias = 1'b0; drv_out_ready = 1'b0; drv_clr = 1'b0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_zero_product();
    test_back_to_back();
    test_random();
    test_wrap();
    test_truncation();
    test_clr_sel();
    test_reset_mid_mult();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
